// File: rtl/volume_peak_scheduler_pkg.sv
// Shared types and widths for the LED bar-graph volume datapath.
// Included by the window detector, the bus interface and the scheduler top.
package volume_peak_scheduler_pkg;

  localparam int LEVEL_W     = 4;
  localparam int MIC_W       = 12;
  localparam int LEVEL_SHIFT = 8;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } peak_state_t;

  // One bar level spans 256 mic counts, so the level is the top nibble of the sample.
  function automatic logic [LEVEL_W-1:0] level_of(input logic [MIC_W-1:0] sample);
    return sample[LEVEL_SHIFT +: LEVEL_W];
  endfunction

endpackage

// File: rtl/volume_peak_scheduler_if.sv
// Sample-in / level-out bus between the mic front end, the scheduler and the LED bar decoder.
// The master side drives samples and the switch; the slave side returns the bar level.
interface volume_peak_scheduler_if;
  import volume_peak_scheduler_pkg::*;

  logic [MIC_W-1:0]   mic_in;
  logic               mic_valid;
  logic               led_data_sw;
  logic [LEVEL_W-1:0] volume_level;
  logic               level_valid;

  modport master (
    output mic_in,
    output mic_valid,
    output led_data_sw,
    input  volume_level,
    input  level_valid
  );

  modport slave (
    input  mic_in,
    input  mic_valid,
    input  led_data_sw,
    output volume_level,
    output level_valid
  );

endinterface

// File: rtl/volume_peak_scheduler_window_peak_detector.sv
// Splits the mic sample stream into fixed-length windows and reports each window's
// peak as a bar level, with a one-cycle win_done strobe after the window closes.
module window_peak_detector
  import volume_peak_scheduler_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 2000
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MIC_W-1:0]   mic_in,
  input  logic               mic_valid,
  output logic [LEVEL_W-1:0] win_level,
  output logic               win_done
);

  localparam int CNT_W = (WINDOW_SAMPLES > 2) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(WINDOW_SAMPLES - 1);

  logic [CNT_W-1:0] sample_cnt;
  logic [MIC_W-1:0] win_max;
  logic [MIC_W-1:0] next_max;

  // The closing sample still has to take part in the window maximum.
  assign next_max = (mic_in > win_max) ? mic_in : win_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      win_max    <= '0;
      win_level  <= '0;
      win_done   <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (mic_valid) begin
        if (sample_cnt == LAST_SAMPLE) begin
          win_level  <= level_of(next_max);
          win_max    <= '0;
          sample_cnt <= '0;
          win_done   <= 1'b1;
        end else begin
          win_max    <= next_max;
          sample_cnt <= sample_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/volume_peak_scheduler.sv
// Peak-hold/decay scheduler for the LED bar graph: windows the mic samples, tracks a
// held peak per window and publishes either the live or the held level to the decoder.
module volume_peak_scheduler
  import volume_peak_scheduler_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 2000,
  parameter int HOLD_WINDOWS   = 5,
  parameter int DECAY_WINDOWS  = 1
)(
  input  logic                   clk,
  input  logic                   rst_n,
  volume_peak_scheduler_if.slave bus
);

  localparam int HOLD_W  = (HOLD_WINDOWS  > 2) ? $clog2(HOLD_WINDOWS)  : 1;
  localparam int DECAY_W = (DECAY_WINDOWS > 2) ? $clog2(DECAY_WINDOWS) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(HOLD_WINDOWS - 1);
  localparam logic [DECAY_W-1:0] DECAY_RELOAD = DECAY_W'(DECAY_WINDOWS - 1);

  logic [LEVEL_W-1:0] win_level;
  logic               win_done;

  peak_state_t        state;
  peak_state_t        state_nxt;
  logic [LEVEL_W-1:0] peak;
  logic [LEVEL_W-1:0] peak_nxt;
  logic [LEVEL_W-1:0] decayed;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_nxt;
  logic [DECAY_W-1:0] decay_cnt;
  logic [DECAY_W-1:0] decay_nxt;

  logic sw_meta;
  logic sw_sync;
  logic update_pending;

  window_peak_detector #(
    .WINDOW_SAMPLES(WINDOW_SAMPLES)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .mic_in   (bus.mic_in),
    .mic_valid(bus.mic_valid),
    .win_level(win_level),
    .win_done (win_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TRACK;
      peak      <= '0;
      hold_cnt  <= '0;
      decay_cnt <= '0;
    end else begin
      state     <= state_nxt;
      peak      <= peak_nxt;
      hold_cnt  <= hold_nxt;
      decay_cnt <= decay_nxt;
    end
  end

  // A new or equal window level always wins and re-arms the hold, whatever the state.
  always_comb begin
    state_nxt = state;
    peak_nxt  = peak;
    hold_nxt  = hold_cnt;
    decay_nxt = decay_cnt;
    decayed   = peak;
    if (win_done) begin
      if (win_level >= peak) begin
        peak_nxt  = win_level;
        hold_nxt  = HOLD_RELOAD;
        state_nxt = HOLD;
      end else begin
        unique case (state)
          HOLD: begin
            if (hold_cnt == '0) begin
              decay_nxt = DECAY_RELOAD;
              state_nxt = DECAY;
            end else begin
              hold_nxt = hold_cnt - HOLD_W'(1);
            end
          end
          DECAY: begin
            if (decay_cnt == '0) begin
              decayed   = peak - LEVEL_W'(1);
              decay_nxt = DECAY_RELOAD;
            end else begin
              decay_nxt = decay_cnt - DECAY_W'(1);
            end
            // peak > win_level here, so the drop can meet but never pass zero.
            if (decayed <= win_level) begin
              peak_nxt  = win_level;
              state_nxt = TRACK;
            end else begin
              peak_nxt = decayed;
            end
          end
          TRACK: begin
            peak_nxt = win_level;
          end
          default: begin
            state_nxt = TRACK;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= bus.led_data_sw;
      sw_sync <= sw_meta;
    end
  end

  // The output is taken one cycle after the FSM so it sees the updated peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_pending   <= 1'b0;
      bus.level_valid  <= 1'b0;
      bus.volume_level <= '0;
    end else begin
      update_pending  <= win_done;
      bus.level_valid <= update_pending;
      if (update_pending) begin
        bus.volume_level <= sw_sync ? peak : win_level;
      end
    end
  end

endmodule

// File: tb/tb_volume_peak_scheduler.sv
// Directed bench for volume_peak_scheduler with a window-level peak model and
// an every-cycle output comparator.
module tb_volume_peak_scheduler;

  localparam int WIN   = 4;
  localparam int HOLDW = 2;
  localparam int DECW  = 1;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t       exp_q[$];
  logic [3:0] seen_q[$];
  logic [3:0] last_level = 4'd0;

  int m_cnt = 0;
  int m_max = 0;
  int m_peak = 0;
  int m_set = 0;
  int m_age = 0;
  bit m_held = 1'b0;

  volume_peak_scheduler_if vif();

  volume_peak_scheduler #(
    .WINDOW_SAMPLES(WIN),
    .HOLD_WINDOWS  (HOLDW),
    .DECAY_WINDOWS (DECW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Held peak as a function of how many windows have passed since it was set.
  task automatic model_window(input int lvl);
    int cand;
    if (lvl >= m_peak) begin
      m_peak = lvl;
      m_set  = lvl;
      m_age  = 0;
      m_held = 1'b1;
    end else if (m_held) begin
      m_age++;
      cand = (m_age < HOLDW) ? m_set : m_set - (m_age - HOLDW) / DECW;
      if (cand <= lvl) begin
        m_peak = lvl;
        m_held = 1'b0;
      end else begin
        m_peak = cand;
      end
    end else begin
      m_peak = lvl;
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] v);
    exp_t e;
    int   lvl;
    @(posedge clk);
    #2;
    vif.mic_valid = 1'b1;
    vif.mic_in    = v;
    if (int'(v) > m_max) m_max = int'(v);
    m_cnt++;
    if (m_cnt == WIN) begin
      lvl = m_max >> 8;
      model_window(lvl);
      e.cyc = cyc + 3;
      e.lvl = vif.led_data_sw ? 4'(m_peak) : 4'(lvl);
      exp_q.push_back(e);
      m_cnt = 0;
      m_max = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      vif.mic_valid = 1'b0;
    end
  endtask

  task automatic set_sw(input logic v);
    @(posedge clk);
    #2;
    vif.led_data_sw = v;
  endtask

  task automatic send_window(input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input logic [11:0] d);
    apply_stimulus(a); idle(1);
    apply_stimulus(b); idle(1);
    apply_stimulus(c); idle(1);
    apply_stimulus(d); idle(1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    vif.mic_valid = 1'b0;
    exp_q.delete();
    seen_q.delete();
    last_level = 4'd0;
    m_cnt = 0; m_max = 0; m_peak = 0; m_set = 0; m_age = 0; m_held = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_output(input string name, input int expv);
    int waited = 0;
    int got;
    while (seen_q.size() == 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (seen_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: no level_valid seen, expected level %0d", name, expv);
    end else begin
      got = int'(seen_q.pop_front());
      if (got != expv) begin
        errors++;
        $display("[TB] FAIL %s: got level %0d, expected %0d", name, got, expv);
      end
    end
  endtask

  task automatic check_now(input string name, input int expv);
    @(negedge clk);
    checks++;
    if (int'(vif.volume_level) != expv) begin
      errors++;
      $display("[TB] FAIL %s: got level %0d, expected %0d", name, vif.volume_level, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      checks++;
      if (vif.volume_level !== 4'd0 || vif.level_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state: got level=%0d valid=%0b, expected 0/0",
                 vif.volume_level, vif.level_valid);
      end
    end else begin
      if (vif.level_valid === 1'b1) seen_q.push_back(vif.volume_level);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missed_update: no pulse at cycle %0d, expected level %0d",
                 exp_q[0].cyc, exp_q[0].lvl);
        void'(exp_q.pop_front());
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (vif.level_valid !== 1'b1 || vif.volume_level !== exp_q[0].lvl) begin
          errors++;
          $display("[TB] FAIL model_update: got level=%0d valid=%0b, expected %0d/1",
                   vif.volume_level, vif.level_valid, exp_q[0].lvl);
        end
        last_level = exp_q[0].lvl;
        void'(exp_q.pop_front());
      end else if (vif.level_valid !== 1'b0 || vif.volume_level !== last_level) begin
        errors++;
        $display("[TB] FAIL model_idle: got level=%0d valid=%0b, expected %0d/0",
                 vif.volume_level, vif.level_valid, last_level);
      end
    end
  end

  initial begin
    int pk_exp[12] = '{10, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 1};
    vif.mic_in      = 12'h000;
    vif.mic_valid   = 1'b0;
    vif.led_data_sw = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    $display("[TB] reset mid-window");
    apply_stimulus(12'hF00); idle(1);
    apply_stimulus(12'hF00); idle(1);
    do_reset();
    send_window(12'h000, 12'h000, 12'h000, 12'h000);
    check_output("reset_restart", 0);

    $display("[TB] live mode");
    send_window(12'h100, 12'hFFF, 12'h200, 12'h050);
    check_output("live_full", 15);
    send_window(12'h3FF, 12'h3FF, 12'h3FF, 12'h3FF);
    check_output("live_three", 3);

    $display("[TB] peak hold and decay");
    do_reset();
    set_sw(1'b1);
    idle(3);
    send_window(12'h000, 12'hA00, 12'h100, 12'h000);
    check_output("peak_set", 10);
    for (int i = 0; i < 12; i++) begin
      send_window(12'h100, 12'h000, 12'h080, 12'h0FF);
      check_output($sformatf("decay_%0d", i), pk_exp[i]);
    end

    $display("[TB] hold re-arm");
    do_reset();
    idle(3);
    send_window(12'hA00, 12'h000, 12'h000, 12'h000);
    check_output("rearm_set", 10);
    send_window(12'h000, 12'hA40, 12'h000, 12'h000);
    check_output("rearm_equal", 10);
    send_window(12'h100, 12'h100, 12'h100, 12'h100);
    check_output("rearm_hold1", 10);
    send_window(12'h100, 12'h100, 12'h100, 12'h100);
    check_output("rearm_hold2", 10);
    send_window(12'h100, 12'h100, 12'h100, 12'h100);
    check_output("rearm_decay", 9);

    $display("[TB] switch synchronisation");
    do_reset();
    idle(3);
    send_window(12'hC00, 12'h000, 12'h000, 12'h000);
    check_output("sw_peak", 12);
    apply_stimulus(12'h400); idle(1);
    apply_stimulus(12'h400); idle(1);
    set_sw(1'b0);
    check_now("sw_no_early_change", 12);
    apply_stimulus(12'h400); idle(1);
    apply_stimulus(12'h400); idle(1);
    check_output("sw_to_live", 4);
    apply_stimulus(12'h400); idle(1);
    set_sw(1'b1);
    check_now("sw_hold_live", 4);
    apply_stimulus(12'h400); idle(1);
    apply_stimulus(12'h400); idle(1);
    apply_stimulus(12'h400); idle(1);
    check_output("sw_to_peak", 12);

    $display("[TB] back-to-back strobes");
    do_reset();
    set_sw(1'b0);
    idle(3);
    for (int i = 0; i < 8; i++) apply_stimulus(12'(i * 12'h200));
    idle(1);
    check_output("b2b_first", 6);
    check_output("b2b_second", 14);

    idle(8);
    checks++;
    if (exp_q.size() != 0 || seen_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d unclaimed=%0d, expected 0/0",
               exp_q.size(), seen_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
